// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid buffer, stall and flush.
// Optional performance counters are enabled by defining PIPE_STAGE_BUF_PERF_EN.
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int NCH    = 6,
  parameter int CTRL_W = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic [NCH*DATA_W-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [NCH*DATA_W-1:0] out_data,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
);

  localparam int PW = NCH * DATA_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CTRL_W-1:0] head_ctrl, head_ctrl_nxt;
  logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_nxt;
  logic [PW-1:0]     head_data, head_data_nxt;
  logic [PW-1:0]     skid_data, skid_data_nxt;
  logic              acc;
  logic              cons;

  // Handshake depends only on registered state and stall, never on in_valid or out_ready.
  assign in_ready  = ~stall & (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_ctrl  = out_valid ? head_ctrl : '0;
  assign out_data  = head_data;
  assign acc       = in_valid & in_ready;
  assign cons      = out_valid & out_ready & ~stall;

  always_comb begin
    state_nxt     = state;
    head_ctrl_nxt = head_ctrl;
    head_data_nxt = head_data;
    skid_ctrl_nxt = skid_ctrl;
    skid_data_nxt = skid_data;
    if (flush) begin
      state_nxt     = EMPTY;
      head_ctrl_nxt = '0;
      head_data_nxt = '0;
      skid_ctrl_nxt = '0;
      skid_data_nxt = '0;
    end else if (!stall) begin
      case (state)
        EMPTY: begin
          if (acc) begin
            state_nxt     = ONE;
            head_ctrl_nxt = in_ctrl;
            head_data_nxt = in_data;
          end
        end
        ONE: begin
          if (acc && !cons) begin
            state_nxt     = FULL;
            skid_ctrl_nxt = in_ctrl;
            skid_data_nxt = in_data;
          end else if (!acc && cons) begin
            state_nxt = EMPTY;
          end else if (acc && cons) begin
            head_ctrl_nxt = in_ctrl;
            head_data_nxt = in_data;
          end
        end
        FULL: begin
          // Skid entry moves up so FIFO order is kept; in_ready is low here so nothing enters.
          if (cons) begin
            state_nxt     = ONE;
            head_ctrl_nxt = skid_ctrl;
            head_data_nxt = skid_data;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      head_ctrl <= '0;
      head_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      state     <= state_nxt;
      head_ctrl <= head_ctrl_nxt;
      head_data <= head_data_nxt;
      skid_ctrl <= skid_ctrl_nxt;
      skid_data <= skid_data_nxt;
    end
  end

`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  // Only flushes that actually discard something are counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall) stall_q <= stall_q + 32'd1;
      if (flush && (state != EMPTY)) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule
